// File: rtl/sprite_draw_pkg.sv
// Shared geometry, tile ids, FSM states and command bundle for the sprite blitter.
// Horizontal mirroring is built only when BLIT_FLIP_EN is defined.
package sprite_draw_pkg;

  localparam int SCREEN_WIDTH  = 320;
  localparam int SCREEN_HEIGHT = 180;
  localparam int SPRITE_SIZE   = 32;
  localparam int SPRITE_NUM    = 8;

  localparam int SIZE_W  = $clog2(SPRITE_SIZE);
  localparam int SPR_W   = 3;
  localparam int COORD_W = 10;
  localparam int SUM_W   = COORD_W + 1;

  localparam logic [SPR_W-1:0] BG    = 3'd0;
  localparam logic [SPR_W-1:0] BL    = 3'd1;
  localparam logic [SPR_W-1:0] FH    = 3'd2;
  localparam logic [SPR_W-1:0] WH    = 3'd3;
  localparam logic [SPR_W-1:0] HD    = 3'd4;
  localparam logic [SPR_W-1:0] SEL   = 3'd5;
  localparam logic [SPR_W-1:0] MODE  = 3'd6;
  localparam logic [SPR_W-1:0] PAUSE = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } blit_state_t;

  typedef struct packed {
    logic [SPR_W-1:0]   sprite;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               flip;
  } blit_cmd_t;

endpackage

// File: rtl/blit_addr_gen.sv
// Tile walker: latches a command, steps row/col (col fastest) and
// derives sprite-ROM address, VRAM address and the per-pixel draw enable.
module blit_addr_gen
  import sprite_draw_pkg::*;
#(
  parameter int VRAM_A_WIDTH      = 16,
  parameter int SPRITEBUF_A_WIDTH = 15
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         step,
  input  blit_cmd_t                    cmd,
  output logic [SPRITEBUF_A_WIDTH-1:0] address_s,
  output logic [VRAM_A_WIDTH-1:0]      address_screen,
  output logic                         pix_on,
  output logic                         last
);

  localparam int PIX_W = 2 * SIZE_W;
  localparam logic [PIX_W-1:0] PIX_ONE = {{(PIX_W-1){1'b0}}, 1'b1};

  logic [SPR_W-1:0]   sprite_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic [PIX_W-1:0]   pix;
  logic [SIZE_W-1:0]  row;
  logic [SIZE_W-1:0]  col;
  logic [SIZE_W-1:0]  col_s;
  logic [SUM_W-1:0]   xs;
  logic [SUM_W-1:0]   ys;
  logic               clip;
  logic               tile_ok;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      sprite_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      pix      <= '0;
    end else if (load) begin
      sprite_q <= cmd.sprite;
      x_q      <= cmd.x;
      y_q      <= cmd.y;
      pix      <= '0;
    end else if (step) begin
      pix <= pix + PIX_ONE;
    end
  end

`ifdef BLIT_FLIP_EN
  logic flip_q;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst)
      flip_q <= 1'b0;
    else if (load)
      flip_q <= cmd.flip;
  end

  // SIZE-1-col is a bitwise invert for a power-of-two tile
  assign col_s = flip_q ? ~col : col;
`else
  logic unused_flip;

  assign unused_flip = cmd.flip;
  assign col_s       = col;
`endif

  assign row = pix[PIX_W-1:SIZE_W];
  assign col = pix[SIZE_W-1:0];
  assign last = &pix;

  assign xs = SUM_W'(x_q) + SUM_W'(col);
  assign ys = SUM_W'(y_q) + SUM_W'(row);

  assign clip = (32'(xs) >= SCREEN_WIDTH) |
                (32'(ys) >= SCREEN_HEIGHT);
  assign tile_ok = 32'(sprite_q) < SPRITE_NUM;
  assign pix_on = tile_ok & ~clip;

  assign address_s = SPRITEBUF_A_WIDTH'(
    32'(sprite_q) * SPRITE_SIZE * SPRITE_SIZE +
    32'(row) * SPRITE_SIZE + 32'(col_s));

  assign address_screen = VRAM_A_WIDTH'(
    32'(ys) * SCREEN_WIDTH + 32'(xs));

endmodule

// File: rtl/sprite_blit_engine.sv
// Sprite blitter top: command handshake, IDLE/RUN/FLUSH control and the
// one-cycle VRAM strobe pipeline. Mirroring enabled by BLIT_FLIP_EN.
module sprite_blit_engine
  import sprite_draw_pkg::*;
#(
  parameter int VRAM_A_WIDTH      = 16,
  parameter int SPRITEBUF_A_WIDTH = 15
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic [SPR_W-1:0]             i_cmd_sprite,
  input  logic [COORD_W-1:0]           i_cmd_x,
  input  logic [COORD_W-1:0]           i_cmd_y,
  input  logic                         i_cmd_flip,
  input  logic                         i_abort,
  output logic [SPRITEBUF_A_WIDTH-1:0] o_address_s,
  output logic [VRAM_A_WIDTH-1:0]      o_address_screen,
  output logic                         o_is_layer_drawing,
  output logic                         o_busy,
  output logic                         o_done
);

  blit_state_t             state;
  blit_cmd_t               cmd;
  logic                    accept;
  logic                    run;
  logic                    pix_on;
  logic                    last;
  logic [VRAM_A_WIDTH-1:0] scr_addr;

  assign cmd = '{
    sprite: i_cmd_sprite,
    x:      i_cmd_x,
    y:      i_cmd_y,
    flip:   i_cmd_flip
  };

  assign accept = (state == IDLE) & i_cmd_valid &
                  o_cmd_ready & ~i_abort;
  assign run = (state == RUN);

  blit_addr_gen #(
    .VRAM_A_WIDTH      (VRAM_A_WIDTH),
    .SPRITEBUF_A_WIDTH (SPRITEBUF_A_WIDTH)
  ) u_addr (
    .CLK            (CLK),
    .rst            (rst),
    .load           (accept),
    .step           (run),
    .cmd            (cmd),
    .address_s      (o_address_s),
    .address_screen (scr_addr),
    .pix_on         (pix_on),
    .last           (last)
  );

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      o_cmd_ready        <= 1'b1;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
      o_is_layer_drawing <= 1'b0;
      o_address_screen   <= '0;
    end else begin
      o_done             <= 1'b0;
      o_is_layer_drawing <= 1'b0;
      if (i_abort) begin
        state       <= IDLE;
        o_cmd_ready <= 1'b1;
        o_busy      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              state       <= RUN;
              o_cmd_ready <= 1'b0;
              o_busy      <= 1'b1;
            end
          end
          RUN: begin
            // clipped pixels leave the VRAM address where it was
            if (pix_on) begin
              o_is_layer_drawing <= 1'b1;
              o_address_screen   <= scr_addr;
            end
            if (last) begin
              state  <= FLUSH;
              o_done <= 1'b1;
            end
          end
          FLUSH: begin
            state       <= IDLE;
            o_cmd_ready <= 1'b1;
            o_busy      <= 1'b0;
          end
          default: begin
            state       <= IDLE;
            o_cmd_ready <= 1'b1;
            o_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Scoreboard bench for sprite_blit_engine: directed plus random commands
// against a pixel-list model of the tile walk.
module tb_sprite_blit_engine;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [2:0]  i_cmd_sprite = '0;
  logic [9:0]  i_cmd_x = '0;
  logic [9:0]  i_cmd_y = '0;
  logic        i_cmd_flip = 1'b0;
  logic        i_abort = 1'b0;
  logic [14:0] o_address_s;
  logic [15:0] o_address_screen;
  logic        o_is_layer_drawing;
  logic        o_busy;
  logic        o_done;

`ifdef BLIT_FLIP_EN
  localparam bit FLIP = 1'b1;
`else
  localparam bit FLIP = 1'b0;
`endif

  sprite_blit_engine dut (
    .CLK                (CLK),
    .rst                (rst),
    .i_cmd_valid        (i_cmd_valid),
    .o_cmd_ready        (o_cmd_ready),
    .i_cmd_sprite       (i_cmd_sprite),
    .i_cmd_x            (i_cmd_x),
    .i_cmd_y            (i_cmd_y),
    .i_cmd_flip         (i_cmd_flip),
    .i_abort            (i_abort),
    .o_address_s        (o_address_s),
    .o_address_screen   (o_address_screen),
    .o_is_layer_drawing (o_is_layer_drawing),
    .o_busy             (o_busy),
    .o_done             (o_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int scr;
    int sa;
  } exp_t;

  exp_t pq[$];
  int   dq[$];
  exp_t e;
  int   cyc = 0;
  int   prev_sa = 0;
  int   n_done = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expected pixels/dones whenever the DUT emits them
  always @(negedge CLK) begin
    if (o_is_layer_drawing) begin
      if (pq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got addr %0d expected no strobe",
                 o_address_screen);
      end else begin
        e = pq.pop_front();
        chk("screen_addr", int'(o_address_screen), e.scr);
        chk("sprite_addr_prev_cycle", prev_sa, e.sa);
      end
    end
    if (o_done) begin
      n_done++;
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none",
                 cyc);
      end else begin
        chk("done_cycle", cyc, dq.pop_front());
        chk("strobes_left_at_done", pq.size(), 0);
      end
    end
    prev_sa = int'(o_address_s);
  end

  // Caller must be at a negedge. lim truncates the expected pixel walk.
  task automatic send(input int sp, input int x, input int y,
                      input int fl, input int lim, input bit hold,
                      output int acc);
    int n = 0;
    int xs, ys, c, r;
    i_cmd_sprite = 3'(sp);
    i_cmd_x      = 10'(x);
    i_cmd_y      = 10'(y);
    i_cmd_flip   = fl[0];
    i_cmd_valid  = 1'b1;
    while (!o_cmd_ready && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!o_cmd_ready) begin
      errors++;
      $display("FAIL accept_timeout: got ready 0 expected 1");
      i_cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    for (int p = 0; p < 1024 && p < lim; p++) begin
      r  = p / 32;
      c  = p % 32;
      xs = x + c;
      ys = y + r;
      if (xs < 320 && ys < 180 && sp < 8)
        pq.push_back('{ys * 320 + xs,
                       sp * 1024 + r * 32 + ((FLIP && fl != 0) ? 31 - c : c)});
    end
    if (lim >= 1024) dq.push_back(acc + 1025);
    @(negedge CLK);
    if (!hold) i_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((dq.size() != 0 || pq.size() != 0) && n < 1500) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (dq.size() != 0 || pq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d strobes %0d dones pending expected 0",
               pq.size(), dq.size());
    end
    @(negedge CLK);
  endtask

  initial begin
    int acc, acc2, a_cyc, nd;
    repeat (3) @(negedge CLK);
    chk("rst_ready", int'(o_cmd_ready), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_strobe", int'(o_is_layer_drawing), 0);
    chk("rst_addr_s", int'(o_address_s), 0);
    chk("rst_addr_screen", int'(o_address_screen), 0);
    rst = 1'b1;
    @(negedge CLK);

    send(1, 10, 20, 0, 1024, 1'b0, acc);
    drain();
    send(3, 300, 170, 0, 1024, 1'b0, acc);
    drain();
    send(2, 0, 0, 1, 1024, 1'b0, acc);
    drain();
    send(7, 320, 0, 0, 1024, 1'b0, acc);
    drain();
    send(4, 0, 180, 1, 1024, 1'b0, acc);
    drain();

    // abort at RUN cycle 100 with a new command already offered
    send(5, 40, 40, 0, 99, 1'b0, acc);
    repeat (99) @(negedge CLK);
    a_cyc = cyc;
    i_abort = 1'b1;
    i_cmd_valid = 1'b1;
    @(negedge CLK);
    i_abort = 1'b0;
    chk("abort_strobe", int'(o_is_layer_drawing), 0);
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_ready", int'(o_cmd_ready), 1);
    chk("abort_pixels_left", pq.size(), 0);
    send(6, 100, 60, 0, 1024, 1'b0, acc2);
    chk("accept_after_abort", acc2, a_cyc + 1);
    drain();

    // abort beats a command in the same idle cycle
    i_cmd_valid = 1'b1;
    i_abort = 1'b1;
    @(negedge CLK);
    chk("idle_abort_busy", int'(o_busy), 0);
    chk("idle_abort_ready", int'(o_cmd_ready), 1);
    i_cmd_valid = 1'b0;
    i_abort = 1'b0;
    repeat (3) @(negedge CLK);
    chk("idle_abort_busy_later", int'(o_busy), 0);

    // valid held across done
    send(0, 200, 100, 0, 1024, 1'b1, acc);
    send(1, 250, 150, 1, 1024, 1'b0, acc2);
    chk("held_valid_accept", acc2, acc + 1026);
    drain();

    repeat (6) begin
      send(int'($urandom_range(0, 7)), int'($urandom_range(0, 340)),
           int'($urandom_range(0, 200)), int'($urandom_range(0, 1)),
           1024, 1'b0, acc);
      drain();
    end

    // asynchronous reset mid-RUN
    send(5, 50, 50, 0, 1024, 1'b0, acc);
    repeat (300) @(negedge CLK);
    nd = n_done;
    #2 rst = 1'b0;
    #1;
    chk("midrun_rst_ready", int'(o_cmd_ready), 1);
    chk("midrun_rst_busy", int'(o_busy), 0);
    chk("midrun_rst_strobe", int'(o_is_layer_drawing), 0);
    chk("midrun_rst_done", int'(o_done), 0);
    chk("midrun_rst_addr_s", int'(o_address_s), 0);
    chk("midrun_rst_addr_screen", int'(o_address_screen), 0);
    pq.delete();
    dq.delete();
    @(negedge CLK);
    rst = 1'b1;
    repeat (1100) @(negedge CLK);
    chk("no_done_after_reset", n_done, nd);
    chk("end_pixels_left", pq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
